// File: rtl/verin_pkg.sv
// verin_pkg: shared state encoding and command/status field layout for the PWM controller
package verin_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DEAD = 2'b10
    } state_e;
    localparam int DUTY_W        = 12;
    localparam int CMD_DUTY_LSB  = 0;
    localparam int CMD_DIR_BIT   = 12;
    localparam int CMD_EN_BIT    = 13;
    localparam int CMD_USED_W    = 14;
    localparam int STS_DUTY_LSB  = 0;
    localparam int STS_EN_BIT    = 12;
    localparam int STS_DIR_BIT   = 13;
    localparam int STS_STATE_LSB = 14;
endpackage

// File: rtl/verin_pwm_counter.sv
// verin_pwm_counter: period counter, wrap detect, duty compare and registered pwm/tick
// ports: clk, reset (sync, active-high); run_i current state is RUN; run_next_i next state is RUN;
//        duty_next_i duty in force next cycle; wrap_o counter at PERIOD-1; pwm_o, tick_o registered
module verin_pwm_counter
    import verin_pkg::*;
#(
    parameter int PERIOD = 2000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run_i,
    input  logic              run_next_i,
    input  logic [DUTY_W-1:0] duty_next_i,
    output logic              wrap_o,
    output logic              pwm_o,
    output logic              tick_o
);
    localparam int CW = $clog2(PERIOD);
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);
    localparam logic [DUTY_W:0] PER = (DUTY_W + 1)'(PERIOD);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [DUTY_W:0] duty_eff;
    logic pwm_q, tick_q;

    assign wrap_o = cnt_q == LAST;
    assign pwm_o  = pwm_q;
    assign tick_o = tick_q;

    // Outputs are computed from next-cycle values so they line up with the state register.
    always_comb begin
        duty_eff = ({1'b0, duty_next_i} > PER) ? PER : {1'b0, duty_next_i};
        cnt_d    = (run_i && run_next_i && !wrap_o) ? cnt_q + 1'b1 : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            pwm_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pwm_q  <= run_next_i && ((DUTY_W + 1)'(cnt_d) < duty_eff);
            tick_q <= run_next_i && (cnt_d == LAST);
        end
    end
endmodule

// File: rtl/verin_pwm_ctrl.sv
// verin_pwm_ctrl: PWM actuator controller with glitch-free duty update and dead-time on reversal
// ports: clk, reset (sync, active-high); cmd_word {ignored, enable, direction, duty[11:0]};
//        pwm_out, dir_out registered bridge drives; period_tick last RUN cycle; status readback
module verin_pwm_ctrl
    import verin_pkg::*;
#(
    parameter int PERIOD    = 2000,
    parameter int DEAD_TIME = 500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cmd_word,
    output logic        pwm_out,
    output logic        dir_out,
    output logic        period_tick,
    output logic [31:0] status
);
    localparam int DW = (DEAD_TIME > 1) ? $clog2(DEAD_TIME) : 1;
    localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_TIME - 1);

    logic [CMD_USED_W-1:0] cmd_q;
    logic unused_cmd;
    state_e state_q, state_d, state_cur;
    logic [DW-1:0] dead_q, dead_d;
    logic [DUTY_W-1:0] duty_q, duty_d, cmd_duty;
    logic dir_q, dir_d, en, cmd_dir, wrap;

    assign unused_cmd = ^cmd_word[31:CMD_USED_W];
    assign en         = cmd_q[CMD_EN_BIT];
    assign cmd_dir    = cmd_q[CMD_DIR_BIT];
    assign cmd_duty   = cmd_q[CMD_DUTY_LSB +: DUTY_W];
    assign dir_out    = dir_q;

    always_comb begin
        state_cur = (state_q == ST_RUN || state_q == ST_DEAD) ? state_q : ST_IDLE;
        state_d   = state_cur;
        dead_d    = '0;
        dir_d     = dir_q;
        if (!en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_cur)
                ST_RUN:  state_d = (wrap && cmd_dir != dir_q) ? ST_DEAD : ST_RUN;
                ST_DEAD: begin
                    // Full dead-time always elapses; direction is sampled only on exit.
                    state_d = (dead_q == DEAD_LAST) ? ST_RUN : ST_DEAD;
                    dir_d   = (dead_q == DEAD_LAST) ? cmd_dir : dir_q;
                    dead_d  = (dead_q == DEAD_LAST) ? '0 : dead_q + 1'b1;
                end
                default: state_d = (cmd_dir == dir_q) ? ST_RUN : ST_DEAD;
            endcase
        end
        duty_d = (state_d == ST_RUN && (state_cur != ST_RUN || wrap)) ? cmd_duty : duty_q;
    end

    always_comb begin
        status = '0;
        status[STS_DUTY_LSB +: DUTY_W] = duty_q;
        status[STS_EN_BIT]             = state_cur != ST_IDLE;
        status[STS_DIR_BIT]            = dir_q;
        status[STS_STATE_LSB +: 2]     = state_cur;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_q   <= '0;
            state_q <= ST_IDLE;
            dead_q  <= '0;
            dir_q   <= 1'b0;
            duty_q  <= '0;
        end else begin
            cmd_q   <= cmd_word[CMD_USED_W-1:0];
            state_q <= state_d;
            dead_q  <= dead_d;
            dir_q   <= dir_d;
            duty_q  <= duty_d;
        end
    end

    verin_pwm_counter #(
        .PERIOD(PERIOD)
    ) u_counter (
        .clk        (clk),
        .reset      (reset),
        .run_i      (state_cur == ST_RUN),
        .run_next_i (state_d == ST_RUN),
        .duty_next_i(duty_d),
        .wrap_o     (wrap),
        .pwm_o      (pwm_out),
        .tick_o     (period_tick)
    );
endmodule

// File: tb/tb_verin_pwm_ctrl.sv
// tb_verin_pwm_ctrl: directed scoreboard bench for verin_pwm_ctrl with PERIOD=10, DEAD_TIME=4
module tb_verin_pwm_ctrl;
    import verin_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [31:0] cmd_word = 32'h0;
    logic pwm_out, dir_out, period_tick;
    logic [31:0] status;

    verin_pwm_ctrl #(
        .PERIOD(10),
        .DEAD_TIME(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_word   (cmd_word),
        .pwm_out    (pwm_out),
        .dir_out    (dir_out),
        .period_tick(period_tick),
        .status     (status)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] sc;
        logic        pwm;
        logic        dir;
        logic        tick;
        logic [31:0] st;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int checks = 0;
    int fails = 0;
    int sc = 0;
    int step = 0;

    function automatic logic [31:0] stw(input logic [1:0] s, input logic d, input logic [11:0] duty);
        return {16'b0, s, d, s != 2'b00, duty};
    endfunction

    task automatic push(input logic p, input logic t, input logic [1:0] s, input logic d, input logic [11:0] duty);
        exp_t x;
        x.sc   = 16'(sc);
        x.pwm  = p;
        x.dir  = d;
        x.tick = t;
        x.st   = stw(s, d, duty);
        q.push_back(x);
    endtask

    task automatic run_part(input logic [11:0] duty, input logic d, input int from, input int to);
        for (int c = from; c <= to; c++) push(c < int'(duty), c == 9, ST_RUN, d, duty);
    endtask

    task automatic period(input logic [11:0] duty, input logic d, input int n);
        for (int i = 0; i < n; i++) run_part(duty, d, 0, 9);
    endtask

    task automatic idle(input int n, input logic d, input logic [11:0] duty);
        for (int i = 0; i < n; i++) push(1'b0, 1'b0, ST_IDLE, d, duty);
    endtask

    task automatic dead(input int n, input logic d, input logic [11:0] duty);
        for (int i = 0; i < n; i++) push(1'b0, 1'b0, ST_DEAD, d, duty);
    endtask

    task automatic drain();
        int n;
        n = q.size();
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        checks++;
        fails++;
        $display("FAIL timeout: stimulus did not complete within 100000 time units");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                checks++;
                step++;
                if ({pwm_out, dir_out, period_tick, status} !== {e.pwm, e.dir, e.tick, e.st}) begin
                    fails++;
                    $display("FAIL sc%0d step%0d pwm/dir/tick/status got %b%b%b %h expected %b%b%b %h",
                             e.sc, step, pwm_out, dir_out, period_tick, status, e.pwm, e.dir, e.tick, e.st);
                end
            end
        end
    end

    initial begin
        @(negedge clk);
        sc = 1;
        idle(2, 1'b0, 12'h000);
        drain();
        checks++;
        if ({pwm_out, dir_out, period_tick, status} !== 35'b0) begin
            fails++;
            $display("FAIL reset state: pwm/dir/tick/status got %b%b%b %h expected all zero",
                     pwm_out, dir_out, period_tick, status);
        end
        reset = 1'b0;
        cmd_word = 32'h0000_2003;
        idle(1, 1'b0, 12'h000);
        period(12'd3, 1'b0, 3);
        drain();

        sc = 2;
        run_part(12'd3, 1'b0, 0, 4);
        drain();
        cmd_word = 32'h0000_2007;
        run_part(12'd3, 1'b0, 5, 9);
        period(12'd7, 1'b0, 2);
        drain();

        sc = 3;
        cmd_word = 32'h0000_2005;
        period(12'd7, 1'b0, 1);
        period(12'd5, 1'b0, 1);
        drain();
        run_part(12'd5, 1'b0, 0, 4);
        drain();
        cmd_word = 32'h0000_3005;
        run_part(12'd5, 1'b0, 5, 9);
        dead(4, 1'b0, 12'd5);
        period(12'd5, 1'b1, 2);
        drain();

        sc = 4;
        cmd_word = 32'h0000_3000;
        period(12'd5, 1'b1, 1);
        period(12'd0, 1'b1, 2);
        drain();
        cmd_word = 32'h0000_3FFF;
        period(12'd0, 1'b1, 1);
        period(12'hFFF, 1'b1, 3);
        drain();

        sc = 5;
        run_part(12'hFFF, 1'b1, 0, 3);
        drain();
        cmd_word = 32'h0000_1FFF;
        run_part(12'hFFF, 1'b1, 4, 4);
        idle(3, 1'b1, 12'hFFF);
        drain();

        sc = 6;
        cmd_word = 32'h0000_2005;
        idle(1, 1'b1, 12'hFFF);
        dead(2, 1'b1, 12'hFFF);
        drain();
        reset = 1'b1;
        idle(2, 1'b0, 12'h000);
        drain();
        reset = 1'b0;
        cmd_word = 32'h0000_2002;
        idle(1, 1'b0, 12'h000);
        period(12'd2, 1'b0, 2);
        drain();

        sc = 7;
        cmd_word = 32'h0000_3002;
        period(12'd2, 1'b0, 1);
        drain();
        dead(1, 1'b0, 12'd2);
        drain();
        cmd_word = 32'h0000_2002;
        dead(3, 1'b0, 12'd2);
        period(12'd2, 1'b0, 1);
        drain();

        sc = 8;
        cmd_word = 32'h0000_3002;
        period(12'd2, 1'b0, 1);
        drain();
        dead(1, 1'b0, 12'd2);
        drain();
        cmd_word = 32'h0000_1002;
        dead(1, 1'b0, 12'd2);
        idle(2, 1'b0, 12'd2);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
